// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned CNT_W      = 4;

    // Requester identifiers, also the encoding of the last-grant flag
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch (I) and load/store (D).
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_PRIO    = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic             last_gnt,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             gnt_i_c,
    output logic             gnt_d_c
);

    // Single requester wins outright; ties resolved by priority mode
    always_comb begin
        gnt_i_c = 1'b0;
        gnt_d_c = 1'b0;
        if (i_req && d_req) begin
            if (DATA_PRIO != 0) begin
                if (starve_cnt == CNT_W'(STARVE_LIMIT)) begin
                    gnt_i_c = 1'b1;
                end else begin
                    gnt_d_c = 1'b1;
                end
            end else if (last_gnt == REQ_D) begin
                gnt_i_c = 1'b1;
            end else begin
                gnt_d_c = 1'b1;
            end
        end else begin
            gnt_i_c = i_req;
            gnt_d_c = d_req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous memory between fetch and load/store,
// one two-cycle access at a time, with a starvation guard for fetch.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned DATA_PRIO    = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              I_Req,
    input  logic [ADDR_W-1:0] I_Addr,
    output logic              I_Gnt,
    output logic              I_Valid,
    output logic [DATA_W-1:0] I_RData,
    input  logic              D_Req,
    input  logic              D_We,
    input  logic [ADDR_W-1:0] D_Addr,
    input  logic [DATA_W-1:0] D_WData,
    output logic              D_Gnt,
    output logic              D_Valid,
    output logic [DATA_W-1:0] D_RData,
    output logic [ADDR_W-1:0] Mem_A,
    output logic [DATA_W-1:0] Mem_WD,
    output logic              Mem_WE,
    input  logic [DATA_W-1:0] Mem_RD
);

    state_t             state_q;
    state_t             state_d;
    logic               arb_en;
    logic               pick_i;
    logic               pick_d;
    logic               last_gnt_q;
    logic [CNT_W-1:0]   starve_cnt_q;
    logic [ADDR_W-1:0]  mem_a_q;
    logic [DATA_W-1:0]  i_hold_q;
    logic [DATA_W-1:0]  d_hold_q;

    // Arbitration only in IDLE and never while reset is asserted
    assign arb_en = Rst_n && (state_q == IDLE);

    mem_arb_pick #(
        .DATA_PRIO    (DATA_PRIO),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .i_req      (I_Req & arb_en),
        .d_req      (D_Req & arb_en),
        .last_gnt   (last_gnt_q),
        .starve_cnt (starve_cnt_q),
        .gnt_i_c    (pick_i),
        .gnt_d_c    (pick_d)
    );

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grant and response strobes
    always_comb begin
        state_d = state_q;
        I_Gnt   = 1'b0;
        D_Gnt   = 1'b0;
        I_Valid = 1'b0;
        D_Valid = 1'b0;
        case (state_q)
            IDLE: begin
                I_Gnt = pick_i;
                D_Gnt = pick_d;
                if (pick_i) begin
                    state_d = RESP_I;
                end else if (pick_d) begin
                    state_d = RESP_D;
                end
            end
            RESP_I: begin
                I_Valid = 1'b1;
                state_d = IDLE;
            end
            RESP_D: begin
                D_Valid = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory port drive: live address in the grant cycle, else last granted
    always_comb begin
        Mem_A  = mem_a_q;
        Mem_WD = D_WData;
        Mem_WE = D_Gnt & D_We;
        if (I_Gnt) begin
            Mem_A = I_Addr;
        end else if (D_Gnt) begin
            Mem_A = D_Addr;
        end
    end

    // Read data passes through in the response cycle, else the held copy
    assign I_RData = I_Valid ? Mem_RD : i_hold_q;
    assign D_RData = D_Valid ? Mem_RD : d_hold_q;

    // Grant bookkeeping: last winner, starvation count, held address
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            last_gnt_q   <= REQ_D;
            starve_cnt_q <= '0;
            mem_a_q      <= '0;
        end else begin
            if (I_Gnt) begin
                last_gnt_q <= REQ_I;
            end else if (D_Gnt) begin
                last_gnt_q <= REQ_D;
            end
            if (I_Gnt || D_Gnt) begin
                mem_a_q <= Mem_A;
            end
            if (state_q == IDLE) begin
                if (I_Gnt || !I_Req) begin
                    starve_cnt_q <= '0;
                end else if (D_Gnt && (starve_cnt_q != CNT_W'(STARVE_LIMIT))) begin
                    starve_cnt_q <= starve_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Capture response data so it stays stable until the next response
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            i_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            if (I_Valid) begin
                i_hold_q <= Mem_RD;
            end
            if (D_Valid) begin
                d_hold_q <= Mem_RD;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiters (data priority and round-robin) share
// stimulus; each has its own memory and is compared every cycle against a
// transaction-level reference model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int          LIM = 4;

    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;

    logic          i_gnt [2];
    logic          d_gnt [2];
    logic          i_valid [2];
    logic          d_valid [2];
    logic          mem_we [2];
    logic [DW-1:0] i_rdata [2];
    logic [DW-1:0] d_rdata [2];
    logic [DW-1:0] mem_wd [2];
    logic [DW-1:0] mem_rd [2];
    logic [AW-1:0] mem_a [2];

    logic [DW-1:0] ram0 [256];
    logic [DW-1:0] ram1 [256];

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DATA_PRIO(1), .STARVE_LIMIT(LIM)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n),
        .I_Req(i_req), .I_Addr(i_addr), .I_Gnt(i_gnt[0]), .I_Valid(i_valid[0]), .I_RData(i_rdata[0]),
        .D_Req(d_req), .D_We(d_we), .D_Addr(d_addr), .D_WData(d_wdata),
        .D_Gnt(d_gnt[0]), .D_Valid(d_valid[0]), .D_RData(d_rdata[0]),
        .Mem_A(mem_a[0]), .Mem_WD(mem_wd[0]), .Mem_WE(mem_we[0]), .Mem_RD(mem_rd[0])
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DATA_PRIO(0), .STARVE_LIMIT(LIM)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n),
        .I_Req(i_req), .I_Addr(i_addr), .I_Gnt(i_gnt[1]), .I_Valid(i_valid[1]), .I_RData(i_rdata[1]),
        .D_Req(d_req), .D_We(d_we), .D_Addr(d_addr), .D_WData(d_wdata),
        .D_Gnt(d_gnt[1]), .D_Valid(d_valid[1]), .D_RData(d_rdata[1]),
        .Mem_A(mem_a[1]), .Mem_WD(mem_wd[1]), .Mem_WE(mem_we[1]), .Mem_RD(mem_rd[1])
    );

    // Synchronous single-port memories with registered read data
    always @(posedge Clk) begin
        if (mem_we[0]) ram0[mem_a[0][7:0]] <= mem_wd[0];
        mem_rd[0] <= ram0[mem_a[0][7:0]];
        if (mem_we[1]) ram1[mem_a[1][7:0]] <= mem_wd[1];
        mem_rd[1] <= ram1[mem_a[1][7:0]];
    end

    // Reference model: 0 = free, 1 = fetch reply due, 2 = data reply due
    int            st [2];
    int            cnt [2];
    int            lastg [2];
    logic [AW-1:0] aq [2];
    logic [DW-1:0] pend [2];
    bit            pstore [2];
    logic [DW-1:0] hold_i [2];
    logic [DW-1:0] hold_d [2];
    bit            hd_known [2];
    logic [DW-1:0] gold [2][256];
    int            seq0 [$];
    int            seq1 [$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            st[k] = 0; cnt[k] = 0; lastg[k] = 1; aq[k] = '0;
            pend[k] = '0; pstore[k] = 1'b0;
            hold_i[k] = '0; hold_d[k] = '0; hd_known[k] = 1'b1;
        end
    endtask

    // Compare one DUT's outputs for the current cycle, then advance its model
    task automatic model_step(input int k);
        bit            ei, ed;
        logic [AW-1:0] ea;
        string         p;
        p = (k == 0) ? "prio" : "rr";
        if (i_gnt[k] === 1'b1) begin if (k == 0) seq0.push_back(0); else seq1.push_back(0); end
        if (d_gnt[k] === 1'b1) begin if (k == 0) seq0.push_back(1); else seq1.push_back(1); end
        if (st[k] == 0) begin
            ei = i_req && (!d_req || ((k == 0) ? (cnt[k] == LIM) : (lastg[k] == 1)));
            ed = d_req && !ei;
            ea = ei ? i_addr : (ed ? d_addr : aq[k]);
            chk($sformatf("%s.i_gnt", p), 32'(i_gnt[k]), 32'(ei));
            chk($sformatf("%s.d_gnt", p), 32'(d_gnt[k]), 32'(ed));
            chk($sformatf("%s.mem_a", p), mem_a[k], ea);
            chk($sformatf("%s.mem_we", p), 32'(mem_we[k]), 32'(ed && d_we));
            chk($sformatf("%s.valid_idle", p), 32'({i_valid[k], d_valid[k]}), 32'd0);
            chk($sformatf("%s.i_hold", p), i_rdata[k], hold_i[k]);
            if (hd_known[k]) chk($sformatf("%s.d_hold", p), d_rdata[k], hold_d[k]);
            if (ed && d_we) chk($sformatf("%s.mem_wd", p), mem_wd[k], d_wdata);
            if (ei) begin
                st[k] = 1; lastg[k] = 0; cnt[k] = 0; aq[k] = i_addr;
                pend[k] = gold[k][i_addr[7:0]]; pstore[k] = 1'b0;
            end else if (ed) begin
                st[k] = 2; lastg[k] = 1; aq[k] = d_addr;
                pend[k] = gold[k][d_addr[7:0]]; pstore[k] = d_we;
                if (d_we) gold[k][d_addr[7:0]] = d_wdata;
                cnt[k] = i_req ? ((cnt[k] + 1 > LIM) ? LIM : cnt[k] + 1) : 0;
            end else begin
                cnt[k] = 0;
            end
        end else begin
            chk($sformatf("%s.gnt_resp", p), 32'({i_gnt[k], d_gnt[k]}), 32'd0);
            chk($sformatf("%s.mem_we_resp", p), 32'(mem_we[k]), 32'd0);
            chk($sformatf("%s.mem_a_resp", p), mem_a[k], aq[k]);
            if (st[k] == 1) begin
                chk($sformatf("%s.i_valid", p), 32'({i_valid[k], d_valid[k]}), 32'd2);
                chk($sformatf("%s.i_rdata", p), i_rdata[k], pend[k]);
                if (hd_known[k]) chk($sformatf("%s.d_hold_r", p), d_rdata[k], hold_d[k]);
                hold_i[k] = pend[k];
            end else begin
                chk($sformatf("%s.d_valid", p), 32'({i_valid[k], d_valid[k]}), 32'd1);
                chk($sformatf("%s.i_hold_r", p), i_rdata[k], hold_i[k]);
                if (!pstore[k]) begin
                    chk($sformatf("%s.d_rdata", p), d_rdata[k], pend[k]);
                    hold_d[k] = pend[k];
                    hd_known[k] = 1'b1;
                end else begin
                    hd_known[k] = 1'b0;
                end
            end
            st[k] = 0;
        end
    endtask

    // One clock: settle, check both DUTs, advance to just after the next edge
    task automatic cycle();
        #1;
        model_step(0);
        model_step(1);
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d.gnt", k), 32'({i_gnt[k], d_gnt[k]}), 32'd0);
            chk($sformatf("rst%0d.valid", k), 32'({i_valid[k], d_valid[k]}), 32'd0);
            chk($sformatf("rst%0d.mem_we", k), 32'(mem_we[k]), 32'd0);
            chk($sformatf("rst%0d.i_rdata", k), i_rdata[k], 32'd0);
            chk($sformatf("rst%0d.d_rdata", k), d_rdata[k], 32'd0);
            chk($sformatf("rst%0d.mem_a", k), mem_a[k], 32'd0);
        end
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        model_reset();
    endtask

    int exp_prio [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int exp_rr   [4]  = '{0, 1, 0, 1};

    initial begin
        Rst_n = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        for (int a = 0; a < 256; a++) begin
            ram0[a] = '0; ram1[a] = '0; gold[0][a] = '0; gold[1][a] = '0;
        end
        ram0[8'h10] = 32'hDEADBEEF; ram1[8'h10] = 32'hDEADBEEF;
        gold[0][8'h10] = 32'hDEADBEEF; gold[1][8'h10] = 32'hDEADBEEF;
        #2;
        i_req = 1'b1; d_req = 1'b1;
        do_reset();
        i_req = 1'b0; d_req = 1'b0;

        // Lone fetch; data must persist in the hold register
        i_req = 1'b1; i_addr = 32'h10;
        cycle();
        i_req = 1'b0;
        repeat (4) cycle();
        chk("fetch_hold", i_rdata[0], 32'hDEADBEEF);

        // Store then load of the same word
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4; d_wdata = 32'h12345678;
        cycle();
        d_req = 1'b0; d_we = 1'b0;
        cycle();
        d_req = 1'b1;
        cycle();
        d_req = 1'b0;
        cycle();
        chk("load_after_store", d_rdata[0], 32'h12345678);

        // D request raised during the fetch response is granted next IDLE
        i_req = 1'b1; i_addr = 32'h10;
        cycle();
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
        cycle();
        #1;
        chk("d_after_resp_i", 32'({d_gnt[0], i_valid[0]}), 32'd2);
        cycle();
        d_req = 1'b0;
        repeat (2) cycle();

        // Both requesters held: starvation pattern and round-robin
        do_reset();
        seq0.delete(); seq1.delete();
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h20; d_addr = 32'h24; d_we = 1'b0;
        repeat (20) cycle();
        chk("seq_prio_len", 32'(seq0.size()), 32'd10);
        chk("seq_rr_len", 32'(seq1.size()), 32'd10);
        for (int n = 0; n < 10; n++)
            if (n < seq0.size()) chk($sformatf("seq_prio[%0d]", n), 32'(seq0[n]), 32'(exp_prio[n]));
        for (int n = 0; n < 4; n++)
            if (n < seq1.size()) chk($sformatf("seq_rr[%0d]", n), 32'(seq1[n]), 32'(exp_rr[n]));
        i_req = 1'b0; d_req = 1'b0;
        repeat (2) cycle();

        // Reset cuts a store's grant cycle: nothing written
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hAAAA5555;
        #1;
        chk("store_we_pre_rst", 32'(mem_we[0]), 32'd1);
        do_reset();
        d_req = 1'b0; d_we = 1'b0;
        chk("rst_starve_cnt", 32'(dut0.starve_cnt_q), 32'd0);
        chk("rst_state", 32'(dut0.state_q), 32'(IDLE));
        d_req = 1'b1;
        cycle();
        d_req = 1'b0;
        cycle();
        chk("load_after_cut_store", d_rdata[0], 32'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            i_req   = 1'($urandom_range(0, 1));
            d_req   = 1'($urandom_range(0, 1));
            d_we    = 1'($urandom_range(0, 1));
            i_addr  = 32'($urandom_range(0, 255));
            d_addr  = 32'($urandom_range(0, 255));
            d_wdata = $urandom;
            cycle();
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (2) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory of the multi-cycle RISC-V core between two requesters: instruction fetch (I) and load/store (D).
- The memory behind it has one synchronous port: address and write data are sampled at posedge Clk, and read data is registered, so it is valid one cycle later.
- The block picks the winner, drives the memory port and returns read data or a write acknowledge with a fixed two-cycle access.
- A starvation counter stops data priority from locking out fetch indefinitely.

Parameters:
ADDR_W, 32, address width of requesters and memory
DATA_W, 32, data width
DATA_PRIO, 1, 1 = D wins ties (subject to starvation limit); 0 = round-robin
STARVE_LIMIT, 4, consecutive D grants while I waits before I is forced; range 1..15

Ports:
Clk  in  1  clock, all state on posedge
Rst_n  in  1  asynchronous active-low reset
I_Req  in  1  fetch request; I_Addr must be held stable until I_Gnt
I_Addr  in  ADDR_W  fetch address
I_Gnt  out  1  fetch granted this cycle (one-cycle pulse)
I_Valid  out  1  fetch data valid (cycle after I_Gnt)
I_RData  out  DATA_W  fetch read data
D_Req  in  1  data request; D_We, D_Addr and D_WData must be held until D_Gnt
D_We  in  1  1 = store, 0 = load
D_Addr  in  ADDR_W  data address
D_WData  in  DATA_W  store data
D_Gnt  out  1  data granted this cycle (one-cycle pulse)
D_Valid  out  1  load data valid, or store acknowledge (cycle after D_Gnt)
D_RData  out  DATA_W  load read data
Mem_A  out  ADDR_W  memory address
Mem_WD  out  DATA_W  memory write data
Mem_WE  out  1  memory write enable
Mem_RD  in  DATA_W  memory read data (registered inside memory)

Behaviour:
- FSM states:
  - IDLE: arbitrate.
  - RESP_I: response to fetch.
  - RESP_D: response to data.
  - Every transition out of RESP_x returns to IDLE, giving one access per two cycles.
- Grants: I_Gnt and D_Gnt are combinational and asserted only in IDLE; they are never high together.
  - IDLE with only one Req: grant it.
  - IDLE with both Req, DATA_PRIO=1: grant D unless starve_cnt == STARVE_LIMIT, in which case grant I.
  - IDLE with both Req, DATA_PRIO=0: grant the requester not granted last (last_gnt flag; reset value = D, so I wins the first tie).
  - IDLE with no Req: no grant; stay in IDLE.
- Transitions: grant I -> RESP_I; grant D -> RESP_D.
- Memory drive in the grant cycle:
  - Mem_A = granted address.
  - Mem_WE = D_Gnt & D_We.
  - Mem_WD = D_WData.
  - Outside grant cycles: Mem_WE = 0 and Mem_A = last granted address (registered; reset value 0).
- Response cycle:
  - RESP_I: I_Valid = 1 and I_RData = Mem_RD.
  - RESP_D: D_Valid = 1, and D_RData = Mem_RD for loads.
  - For stores, D_Valid is the write acknowledge and D_RData is don't-care.
  - xRData is also captured into a hold register at the end of the response cycle and held stable until that requester's next Valid.
- Latency: Gnt in cycle N, Valid in cycle N+1. The earliest next grant is N+2.
- Starvation counter (starve_cnt, 4 bits):
  - Increments on each D grant while I_Req is high and saturates at STARVE_LIMIT.
  - Clears on any I grant.
  - Clears when I_Req is low in IDLE.
- Req held high through the response cycle is treated as a fresh request in the following IDLE; a requester issues back-to-back accesses by keeping Req high.
- Req dropped before its grant is simply not served; there is no error.
- Reset (asynchronous, any state, including mid-access):
  - State = IDLE.
  - Gnt, Valid and Mem_WE = 0 immediately.
  - starve_cnt = 0; last_gnt = D.
  - Hold registers, xRData and the Mem_A register = 0.
  - A store whose grant cycle is cut by reset before the edge is not written; the requester must re-request.

Decomposition:
- Shared package mem_arb_pkg:
  - State enum {IDLE, RESP_I, RESP_D}.
  - Requester-id constants REQ_I/REQ_D.
  - Default ADDR_W/DATA_W.
- One sub-module, mem_arb_pick: pure combinational winner selection from I_Req, D_Req, DATA_PRIO, last_gnt, starve_cnt and STARVE_LIMIT. The FSM, counter and registers stay in the top module.

Test Plan:
- Fetch alone, I_Addr=0x10, memory word 0x10 = 0xDEADBEEF -> I_Gnt in cycle 1, Mem_A=0x10, Mem_WE=0; I_Valid in cycle 2 with I_RData=0xDEADBEEF; I_RData still 0xDEADBEEF in cycle 5.
- Store then load: D_We=1, D_Addr=0x4, D_WData=0x12345678, then D_We=0 same address -> Mem_WE high only in the first grant cycle; store ack D_Valid; load returns D_Valid with D_RData=0x12345678.
- DATA_PRIO=1, STARVE_LIMIT=4, I_Req and D_Req held high continuously -> grant sequence D,D,D,D,I,D,D,D,D,I; never two grants within 2 cycles.
- DATA_PRIO=0, both Req held high -> grants alternate I,D,I,D, starting with I after reset.
- Rst_n pulled low in the grant cycle of a store to 0x8 (old value 0x0) -> Mem_WE drops immediately; after reset, a load of 0x8 returns 0x0; starve_cnt=0 and state=IDLE.
- D_Req asserted in RESP_I -> D_Gnt exactly in the next IDLE cycle, with no overlap with I_Valid.
